// File: rtl/cmp_sar_search.sv
// cmp_sar_search: successive-approximation search over an external comparator.
// Drives a probe value on guess, reads back eq/gt/lt from the comparator and
// narrows the [lo, hi] window by halving it until the hidden operand is hit,
// the comparator reports an illegal flag combination, or the window empties.
module cmp_sar_search #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] probes
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  // Window bounds carry one extra bit so guess+1 at the top of the range and
  // the lo+1 comparison near guess=0 never wrap.
  localparam logic [WIDTH:0] HI_INIT = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE_W   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] FIRST_GUESS = WIDTH'(HI_INIT >> 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] guess_n;
  logic [WIDTH:0]   lo, lo_n;
  logic [WIDTH:0]   hi, hi_n;
  logic             found_n;
  logic             error_n;
  logic [WIDTH-1:0] result_n;
  logic [CNT_W-1:0] probes_n;

  // Helper terms for the window update.
  logic [WIDTH:0]   guess_w;
  logic [WIDTH:0]   gt_hi;
  logic [WIDTH:0]   lt_lo;
  logic [WIDTH:0]   mid_sum;
  logic             gt_cross;
  logic             lt_cross;

  // Next-state, window and output-register update.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    guess_n  = guess;
    lo_n     = lo;
    hi_n     = hi;
    found_n  = found;
    error_n  = error;
    result_n = result;
    probes_n = probes;

    guess_w  = {1'b0, guess};
    gt_hi    = guess_w - ONE_W;
    lt_lo    = guess_w + ONE_W;
    // guess - 1 < lo  is the same as  lo + 1 > guess, which cannot underflow.
    gt_cross = (lo + ONE_W) > guess_w;
    lt_cross = lt_lo > hi;
    mid_sum  = '0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_PROBE;
          lo_n     = '0;
          hi_n     = HI_INIT;
          guess_n  = FIRST_GUESS;
          found_n  = 1'b0;
          error_n  = 1'b0;
          result_n = '0;
          probes_n = CNT_W'(1);
        end
      end

      S_PROBE: begin
        unique case ({cmp_eq, cmp_gt, cmp_lt})
          3'b100: begin
            result_n = guess;
            found_n  = 1'b1;
            state_n  = S_FIN;
          end
          3'b010: begin
            if (gt_cross) begin
              error_n = 1'b1;
              state_n = S_FIN;
            end else begin
              hi_n     = gt_hi;
              mid_sum  = lo + gt_hi;
              guess_n  = WIDTH'(mid_sum >> 1);
              probes_n = probes + CNT_W'(1);
            end
          end
          3'b001: begin
            if (lt_cross) begin
              error_n = 1'b1;
              state_n = S_FIN;
            end else begin
              lo_n     = lt_lo;
              mid_sum  = lt_lo + hi;
              guess_n  = WIDTH'(mid_sum >> 1);
              probes_n = probes + CNT_W'(1);
            end
          end
          default: begin
            // No flag or several flags: the comparator is not trustworthy.
            error_n = 1'b1;
            state_n = S_FIN;
          end
        endcase
      end

      S_FIN: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      guess  <= '0;
      lo     <= '0;
      hi     <= HI_INIT;
      found  <= 1'b0;
      error  <= 1'b0;
      result <= '0;
      probes <= '0;
    end else begin
      state  <= state_n;
      guess  <= guess_n;
      lo     <= lo_n;
      hi     <= hi_n;
      found  <= found_n;
      error  <= error_n;
      result <= result_n;
      probes <= probes_n;
    end
  end

  // Status flags decode straight from the registered state.
  assign busy = (state == S_PROBE);
  assign done = (state == S_FIN);

endmodule
